hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_if.sv | 28 ++
 rtl/hazard_controller.sv | 102 ++++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// ID-stage hazard interface: decoded instruction fields in, pipeline control out.
interface hazard_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic             id_rs_used;
    logic [4:0]       id_rt;
    logic             id_rt_used;
    logic             id_wr_en;
    logic [4:0]       id_wr_id;
    logic             id_jr;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic             id_kill;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_wr_en, id_wr_id, id_jr,
        input  stall, bubble, flush, id_kill, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_wr_en, id_wr_id, id_jr,
        output stall, bubble, flush, id_kill, stall_cycles
    );
endinterface

// File: rtl/hazard_controller.sv
// In-order pipeline RAW hazard detector with jr flush sequencing and stall counter.
// Define REGFILE_BYPASS_EN for a write-through register file (WB slot not matched).
module hazard_controller #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_controller_if.slave bus
);

`ifdef REGFILE_BYPASS_EN
    localparam int unsigned N_CHK = DEPTH - 1;
`else
    localparam int unsigned N_CHK = DEPTH;
`endif

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_FLUSH
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [DEPTH-1:0] slot_valid;
    logic [4:0]       slot_id [DEPTH];
    logic             rs_match;
    logic             rt_match;
    logic             rs_hit;
    logic             rt_hit;
    logic             hazard;
    logic             jr_take;
    logic             kill;
    logic             slot_load;
    logic [CNT_W-1:0] cnt;

    // Compare both sources against every in-flight writer that is not yet readable.
    always_comb begin
        rs_match = 1'b0;
        rt_match = 1'b0;
        for (int unsigned i = 0; i < N_CHK; i++) begin
            if (slot_valid[i] && (slot_id[i] == bus.id_rs)) rs_match = 1'b1;
            if (slot_valid[i] && (slot_id[i] == bus.id_rt)) rt_match = 1'b1;
        end
    end

    assign rs_hit = rs_match && bus.id_rs_used && (bus.id_rs != 5'd0);
    assign rt_hit = rt_match && bus.id_rt_used && (bus.id_rt != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= next_state;
    end

    // The FLUSH cycle squashes the ID instruction and masks every control output.
    always_comb begin
        next_state = state;
        kill       = (state == S_FLUSH);
        hazard     = 1'b0;
        jr_take    = 1'b0;
        if (!kill) begin
            hazard  = bus.id_valid && (rs_hit || rt_hit);
            jr_take = bus.id_valid && bus.id_jr && !hazard;
        end
        case (state)
            S_RUN, S_STALL: begin
                if (hazard)       next_state = S_STALL;
                else if (jr_take) next_state = S_FLUSH;
                else              next_state = S_RUN;
            end
            S_FLUSH: next_state = S_RUN;
            default: next_state = S_RUN;
        endcase
    end

    assign slot_load = bus.id_valid && bus.id_wr_en && (bus.id_wr_id != 5'd0) && !hazard && !kill;

    // Writer scoreboard: slot 0 is s2, slot DEPTH-1 is WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) slot_id[i] <= 5'd0;
        end else begin
            slot_valid <= {slot_valid[DEPTH-2:0], slot_load};
            slot_id[0] <= bus.id_wr_id;
            for (int unsigned i = 1; i < DEPTH; i++) slot_id[i] <= slot_id[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                      cnt <= '0;
        else if (hazard && (cnt != '1)) cnt <= cnt + CNT_W'(1);
    end

    assign bus.stall        = hazard;
    assign bus.bubble       = hazard;
    assign bus.flush        = jr_take;
    assign bus.id_kill      = kill;
    assign bus.stall_cycles = cnt;

endmodule
